// File: rtl/branch_resolve_unit.sv
// Branch condition handler between the ALU and the PC/IF stage.
// Keeps the architectural Z/N/C/V flags, forwards a same-cycle flag write into
// the branch decision, holds a branch while a flag producer is still in flight,
// and turns a taken branch into a PC-load pulse plus a multi-cycle flush.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | ready for a branch request (br_ready=1)
// S_WAIT     | branch latched, flags not final yet; upstream stalled
// S_RESOLVE  | one-cycle outcome: pc_load/flush/link_we for a taken branch
// S_FLUSH    | remaining flush cycles after RESOLVE for long flushes
`timescale 1ns/1ps

module branch_resolve_unit #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int LINK_OFFSET  = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_we,
    input  logic [3:0]        flag_in,
    input  logic              flags_busy,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic              br_link,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_target,
    output logic              stall,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_addr,
    output logic [3:0]        flags_q,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    // Flush down-counter only needs to hold FLUSH_CYCLES-2.
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESOLVE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t            state_q;
    logic [3:0]        arch_flags_q;
    logic [2:0]        cond_q;
    logic              link_q;
    logic              taken_q;
    logic [FCW-1:0]    flush_cnt_q;
    logic              br_ready_q;
    logic              stall_q;
    logic              pc_load_q;
    logic              flush_q;
    logic              link_we_q;
    logic [ADDR_W-1:0] pc_target_q;
    logic [ADDR_W-1:0] link_addr_q;
    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  taken_cnt_q;

    logic [3:0]        eff_flags_d;
    logic [2:0]        cond_d;
    logic              link_d;
    logic              taken_d;
    logic              resolve_d;

    // Z = F[3], N = F[2]; C and V ride along but never gate a branch.
    function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] f);
        logic z;
        logic n;
        z = f[3];
        n = f[2];
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = z;
            3'b010:  cond_true = z | ~n;
            3'b011:  cond_true = ~z & ~n;
            3'b100:  cond_true = z | n;
            3'b101:  cond_true = ~z & n;
            3'b110:  cond_true = ~z;
            default: cond_true = 1'b0;
        endcase
    endfunction

    // Branch decision: fresh request fields in IDLE, latched ones while waiting.
    always_comb begin
        eff_flags_d = flag_we ? flag_in : arch_flags_q;
        cond_d      = (state_q == S_IDLE) ? br_cond : cond_q;
        link_d      = (state_q == S_IDLE) ? br_link : link_q;
        taken_d     = cond_true(cond_d, eff_flags_d);
        resolve_d   = 1'b0;
        if (!flags_busy) begin
            if (state_q == S_IDLE && br_valid) resolve_d = 1'b1;
            if (state_q == S_WAIT)             resolve_d = 1'b1;
        end
    end

    // Sequencer, flag register, registered outputs and saturating statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            arch_flags_q <= 4'b0000;
            cond_q       <= 3'b000;
            link_q       <= 1'b0;
            taken_q      <= 1'b0;
            flush_cnt_q  <= '0;
            br_ready_q   <= 1'b1;
            stall_q      <= 1'b0;
            pc_load_q    <= 1'b0;
            flush_q      <= 1'b0;
            link_we_q    <= 1'b0;
            pc_target_q  <= '0;
            link_addr_q  <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            if (flag_we) arch_flags_q <= flag_in;

            // Pulses default low; only the resolve step raises them.
            pc_load_q <= 1'b0;
            link_we_q <= 1'b0;

            if (state_q == S_IDLE && br_valid) begin
                cond_q      <= br_cond;
                link_q      <= br_link;
                pc_target_q <= br_target;
                link_addr_q <= br_pc + ADDR_W'(LINK_OFFSET);
                br_ready_q  <= 1'b0;
            end

            if (resolve_d) begin
                state_q      <= S_RESOLVE;
                stall_q      <= 1'b0;
                br_ready_q   <= 1'b0;
                taken_q      <= taken_d;
                pc_load_q    <= taken_d;
                flush_q      <= taken_d;
                link_we_q    <= taken_d & link_d;
                if (branch_cnt_q != {CNT_W{1'b1}})
                    branch_cnt_q <= branch_cnt_q + CNT_W'(1);
                if (taken_d && taken_cnt_q != {CNT_W{1'b1}})
                    taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (br_valid) begin
                            state_q <= S_WAIT;
                            stall_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        stall_q <= 1'b1;
                    end
                    S_RESOLVE: begin
                        if (taken_q && FLUSH_CYCLES > 1) begin
                            state_q     <= S_FLUSH;
                            flush_q     <= 1'b1;
                            flush_cnt_q <= FCW'(FLUSH_CYCLES - 2);
                        end else begin
                            state_q    <= S_IDLE;
                            flush_q    <= 1'b0;
                            br_ready_q <= 1'b1;
                        end
                    end
                    S_FLUSH: begin
                        if (flush_cnt_q == '0) begin
                            state_q    <= S_IDLE;
                            flush_q    <= 1'b0;
                            br_ready_q <= 1'b1;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - FCW'(1);
                        end
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        flush_q    <= 1'b0;
                        stall_q    <= 1'b0;
                        br_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign br_ready   = br_ready_q;
    assign stall      = stall_q;
    assign pc_load    = pc_load_q;
    assign pc_target  = pc_target_q;
    assign flush      = flush_q;
    assign link_we    = link_we_q;
    assign link_addr  = link_addr_q;
    assign flags_q    = arch_flags_q;
    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Two instances share the inputs:
// "a" has a 3-cycle flush and 2-bit counters, "b" has the default 1-cycle
// flush and 16-bit counters.
`timescale 1ns/1ps

module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        flag_we;
    logic [3:0]  flag_in;
    logic        flags_busy;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic        br_link;
    logic [31:0] br_pc;
    logic [31:0] br_target;

    logic        br_ready_a, stall_a, pc_load_a, flush_a, link_we_a;
    logic [31:0] pc_target_a, link_addr_a;
    logic [3:0]  flags_q_a;
    logic [1:0]  branch_cnt_a, taken_cnt_a;

    logic        br_ready_b, stall_b, pc_load_b, flush_b, link_we_b;
    logic [31:0] pc_target_b, link_addr_b;
    logic [3:0]  flags_q_b;
    logic [15:0] branch_cnt_b, taken_cnt_b;

    int compared;
    int mismatched;
    int exp_b;
    int exp_t;

    branch_resolve_unit #(.ADDR_W(32), .FLUSH_CYCLES(3), .LINK_OFFSET(4), .CNT_W(2)) dut_a (
        .clk(clk), .reset(rst), .flag_we(flag_we), .flag_in(flag_in), .flags_busy(flags_busy),
        .br_valid(br_valid), .br_ready(br_ready_a), .br_cond(br_cond), .br_link(br_link),
        .br_pc(br_pc), .br_target(br_target), .stall(stall_a), .pc_load(pc_load_a),
        .pc_target(pc_target_a), .flush(flush_a), .link_we(link_we_a), .link_addr(link_addr_a),
        .flags_q(flags_q_a), .branch_cnt(branch_cnt_a), .taken_cnt(taken_cnt_a)
    );

    branch_resolve_unit #(.ADDR_W(32), .FLUSH_CYCLES(1), .LINK_OFFSET(4), .CNT_W(16)) dut_b (
        .clk(clk), .reset(rst), .flag_we(flag_we), .flag_in(flag_in), .flags_busy(flags_busy),
        .br_valid(br_valid), .br_ready(br_ready_b), .br_cond(br_cond), .br_link(br_link),
        .br_pc(br_pc), .br_target(br_target), .stall(stall_b), .pc_load(pc_load_b),
        .pc_target(pc_target_b), .flush(flush_b), .link_we(link_we_b), .link_addr(link_addr_b),
        .flags_q(flags_q_b), .branch_cnt(branch_cnt_b), .taken_cnt(taken_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_b = 0;
        exp_t = 0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        flag_we = 1'b1;
        flag_in = f;
        tick();
        flag_we = 1'b0;
    endtask

    task automatic do_branch(input logic [2:0] c, input logic l, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic will_take);
        br_valid  = 1'b1;
        br_cond   = c;
        br_link   = l;
        br_pc     = pc;
        br_target = tgt;
        tick();
        br_valid  = 1'b0;
        exp_b++;
        if (will_take) exp_t++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(br_ready_a && br_ready_b) && n < 10) begin
            tick();
            n++;
        end
        compared++;
        if (!(br_ready_a && br_ready_b)) begin
            mismatched++;
            $display("FAIL wait_idle: br_ready a=%0b b=%0b want 1/1 within 10 cycles", br_ready_a, br_ready_b);
        end
    endtask

    task automatic test_reset();
        compared++;
        if ({br_ready_a, stall_a, pc_load_a, flush_a, link_we_a} !== 5'b10000) begin
            mismatched++;
            $display("FAIL reset_ctrl_a: got %b want 10000", {br_ready_a, stall_a, pc_load_a, flush_a, link_we_a});
        end
        compared++;
        if ({br_ready_b, stall_b, pc_load_b, flush_b, link_we_b} !== 5'b10000) begin
            mismatched++;
            $display("FAIL reset_ctrl_b: got %b want 10000", {br_ready_b, stall_b, pc_load_b, flush_b, link_we_b});
        end
        compared++;
        if ({flags_q_a, branch_cnt_a, taken_cnt_a} !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_regs_a: got %h want 00", {flags_q_a, branch_cnt_a, taken_cnt_a});
        end
        compared++;
        if ({pc_target_a, link_addr_a} !== 64'h0) begin
            mismatched++;
            $display("FAIL reset_addr_a: got %h want 0", {pc_target_a, link_addr_a});
        end
    endtask

    task automatic test_eq_taken();
        set_flags(4'b1000);
        compared++;
        if (flags_q_a !== 4'b1000) begin
            mismatched++;
            $display("FAIL eq_flags: got %b want 1000", flags_q_a);
        end
        do_branch(3'b001, 1'b0, 32'h50, 32'h100, 1'b1);
        compared++;
        if ({pc_load_a, flush_a, link_we_a, br_ready_a} !== 4'b1100) begin
            mismatched++;
            $display("FAIL eq_pulse: got %b want 1100", {pc_load_a, flush_a, link_we_a, br_ready_a});
        end
        compared++;
        if (pc_target_a !== 32'h100) begin
            mismatched++;
            $display("FAIL eq_target: got %h want 00000100", pc_target_a);
        end
        compared++;
        if (taken_cnt_a !== 2'd1 || branch_cnt_a !== 2'd1) begin
            mismatched++;
            $display("FAIL eq_counts: got taken=%0d branch=%0d want 1/1", taken_cnt_a, branch_cnt_a);
        end
        compared++;
        if ({pc_load_b, flush_b} !== 2'b11) begin
            mismatched++;
            $display("FAIL eq_pulse_b: got %b want 11", {pc_load_b, flush_b});
        end
        tick();
        compared++;
        if ({pc_load_a, flush_a, br_ready_a} !== 3'b010) begin
            mismatched++;
            $display("FAIL flush_c2_a: got %b want 010", {pc_load_a, flush_a, br_ready_a});
        end
        compared++;
        if ({pc_load_b, flush_b, br_ready_b} !== 3'b001) begin
            mismatched++;
            $display("FAIL flush_end_b: got %b want 001", {pc_load_b, flush_b, br_ready_b});
        end
        tick();
        compared++;
        if ({flush_a, br_ready_a} !== 2'b10) begin
            mismatched++;
            $display("FAIL flush_c3_a: got %b want 10", {flush_a, br_ready_a});
        end
        tick();
        compared++;
        if ({flush_a, br_ready_a} !== 2'b01) begin
            mismatched++;
            $display("FAIL flush_end_a: got %b want 01", {flush_a, br_ready_a});
        end
    endtask

    task automatic test_forward();
        // Stored Z=1 would make LTZ fail; the forwarded N=1,Z=0 must win.
        flag_we = 1'b1;
        flag_in = 4'b0100;
        do_branch(3'b101, 1'b0, 32'h60, 32'h180, 1'b1);
        flag_we = 1'b0;
        compared++;
        if ({pc_load_a, pc_load_b} !== 2'b11) begin
            mismatched++;
            $display("FAIL fwd_taken: got %b want 11", {pc_load_a, pc_load_b});
        end
        compared++;
        if (flags_q_a !== 4'b0100) begin
            mismatched++;
            $display("FAIL fwd_flags: got %b want 0100", flags_q_a);
        end
        wait_idle();
        // Stored N=1 would take LTZ; the forwarded Z=1 must block it.
        flag_we = 1'b1;
        flag_in = 4'b1000;
        do_branch(3'b101, 1'b0, 32'h64, 32'h1C0, 1'b0);
        flag_we = 1'b0;
        compared++;
        if ({pc_load_a, flush_a, pc_load_b, flush_b} !== 4'b0000) begin
            mismatched++;
            $display("FAIL fwd_not_taken: got %b want 0000", {pc_load_a, flush_a, pc_load_b, flush_b});
        end
        wait_idle();
    endtask

    task automatic test_cond_table();
        // {flags, cond, expected taken}
        logic [7:0] vec [16];
        logic [7:0] v;
        vec = '{
            {4'b0000, 3'b011, 1'b1}, {4'b0000, 3'b100, 1'b0}, {4'b0000, 3'b110, 1'b1},
            {4'b0000, 3'b010, 1'b1}, {4'b1000, 3'b100, 1'b1}, {4'b1000, 3'b110, 1'b0},
            {4'b1000, 3'b011, 1'b0}, {4'b1000, 3'b001, 1'b1}, {4'b0100, 3'b101, 1'b1},
            {4'b0100, 3'b001, 1'b0}, {4'b0100, 3'b010, 1'b0}, {4'b1100, 3'b010, 1'b1},
            {4'b1100, 3'b101, 1'b0}, {4'b0011, 3'b000, 1'b1}, {4'b0011, 3'b111, 1'b0},
            {4'b0011, 3'b011, 1'b1}
        };
        for (int i = 0; i < 16; i++) begin
            v = vec[i];
            set_flags(v[7:4]);
            do_branch(v[3:1], 1'b0, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 16), v[0]);
            compared++;
            if ({pc_load_b, flush_b, pc_load_a} !== {3{v[0]}}) begin
                mismatched++;
                $display("FAIL cond_%0d flags=%b cond=%b: got %b want %b", i, v[7:4], v[3:1],
                         {pc_load_b, flush_b, pc_load_a}, {3{v[0]}});
            end
            wait_idle();
        end
        compared++;
        if (branch_cnt_b !== 16'(exp_b) || taken_cnt_b !== 16'(exp_t)) begin
            mismatched++;
            $display("FAIL cond_counts_b: got %0d/%0d want %0d/%0d", branch_cnt_b, taken_cnt_b, exp_b, exp_t);
        end
    endtask

    task automatic test_wait();
        set_flags(4'b1000);
        flags_busy = 1'b1;
        do_branch(3'b011, 1'b0, 32'h300, 32'h200, 1'b1);
        compared++;
        if ({stall_a, br_ready_a, pc_load_a} !== 3'b100) begin
            mismatched++;
            $display("FAIL wait_c1: got %b want 100", {stall_a, br_ready_a, pc_load_a});
        end
        // A request outside IDLE must be ignored.
        br_valid  = 1'b1;
        br_cond   = 3'b000;
        br_target = 32'h999;
        tick();
        br_valid  = 1'b0;
        compared++;
        if ({stall_a, stall_b, pc_load_a} !== 3'b110) begin
            mismatched++;
            $display("FAIL wait_c2: got %b want 110", {stall_a, stall_b, pc_load_a});
        end
        tick();
        compared++;
        if ({stall_a, pc_load_a} !== 2'b10) begin
            mismatched++;
            $display("FAIL wait_c3: got %b want 10", {stall_a, pc_load_a});
        end
        flags_busy = 1'b0;
        flag_we    = 1'b1;
        flag_in    = 4'b0000;
        tick();
        flag_we    = 1'b0;
        compared++;
        if ({stall_a, pc_load_a, flush_a, pc_load_b} !== 4'b0111) begin
            mismatched++;
            $display("FAIL wait_resolve: got %b want 0111", {stall_a, pc_load_a, flush_a, pc_load_b});
        end
        compared++;
        if (pc_target_a !== 32'h200) begin
            mismatched++;
            $display("FAIL wait_target: got %h want 00000200", pc_target_a);
        end
        wait_idle();
        compared++;
        if (branch_cnt_b !== 16'(exp_b)) begin
            mismatched++;
            $display("FAIL wait_ignore_cnt: got %0d want %0d", branch_cnt_b, exp_b);
        end
    endtask

    task automatic test_link();
        do_branch(3'b000, 1'b1, 32'hFFFF_FFFC, 32'h40, 1'b1);
        compared++;
        if ({link_we_a, pc_load_a, link_we_b} !== 3'b111) begin
            mismatched++;
            $display("FAIL link_pulse: got %b want 111", {link_we_a, pc_load_a, link_we_b});
        end
        compared++;
        if (link_addr_a !== 32'h0) begin
            mismatched++;
            $display("FAIL link_wrap: got %h want 00000000", link_addr_a);
        end
        tick();
        compared++;
        if ({link_we_a, link_we_b} !== 2'b00) begin
            mismatched++;
            $display("FAIL link_one_cycle: got %b want 00", {link_we_a, link_we_b});
        end
        wait_idle();
        do_branch(3'b111, 1'b1, 32'h10, 32'h80, 1'b0);
        compared++;
        if ({pc_load_a, flush_a, link_we_a, link_we_b} !== 4'b0000) begin
            mismatched++;
            $display("FAIL never_quiet: got %b want 0000", {pc_load_a, flush_a, link_we_a, link_we_b});
        end
        compared++;
        if (branch_cnt_b !== 16'(exp_b) || taken_cnt_b !== 16'(exp_t)) begin
            mismatched++;
            $display("FAIL never_counts: got %0d/%0d want %0d/%0d", branch_cnt_b, taken_cnt_b, exp_b, exp_t);
        end
        wait_idle();
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_branch(3'b000, 1'b0, 32'h0, 32'h400 + 32'(i * 16), 1'b1);
            wait_idle();
        end
        compared++;
        if (taken_cnt_a !== 2'd3 || branch_cnt_a !== 2'd3) begin
            mismatched++;
            $display("FAIL sat_a: got taken=%0d branch=%0d want 3/3", taken_cnt_a, branch_cnt_a);
        end
        compared++;
        if (taken_cnt_b !== 16'd5 || branch_cnt_b !== 16'd5) begin
            mismatched++;
            $display("FAIL sat_b: got taken=%0d branch=%0d want 5/5", taken_cnt_b, branch_cnt_b);
        end
    endtask

    task automatic test_reset_mid_wait();
        flags_busy = 1'b1;
        do_branch(3'b000, 1'b0, 32'h0, 32'h700, 1'b1);
        compared++;
        if (stall_a !== 1'b1) begin
            mismatched++;
            $display("FAIL rwait_pre: got stall=%b want 1", stall_a);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({stall_a, br_ready_a, stall_b, br_ready_b} !== 4'b0101) begin
            mismatched++;
            $display("FAIL rwait_drop: got %b want 0101", {stall_a, br_ready_a, stall_b, br_ready_b});
        end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        flags_busy = 1'b0;
        exp_b = 0;
        exp_t = 0;
        tick();
        compared++;
        if ({pc_load_a, flush_a, stall_a, br_ready_a, branch_cnt_a} !== 6'b000100) begin
            mismatched++;
            $display("FAIL rwait_discard: got %b want 000100", {pc_load_a, flush_a, stall_a, br_ready_a, branch_cnt_a});
        end
    endtask

    task automatic test_reset_mid_flush();
        set_flags(4'b0000);
        do_branch(3'b000, 1'b0, 32'h0, 32'h500, 1'b1);
        tick();
        compared++;
        if ({flush_a, pc_load_a} !== 2'b10) begin
            mismatched++;
            $display("FAIL rflush_pre: got %b want 10", {flush_a, pc_load_a});
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({flush_a, br_ready_a, taken_cnt_a, branch_cnt_a} !== 6'b010000) begin
            mismatched++;
            $display("FAIL rflush_drop: got %b want 010000", {flush_a, br_ready_a, taken_cnt_a, branch_cnt_a});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_b = 0;
        exp_t = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        exp_b      = 0;
        exp_t      = 0;
        rst        = 1'b1;
        flag_we    = 1'b0;
        flag_in    = 4'b0000;
        flags_busy = 1'b0;
        br_valid   = 1'b0;
        br_cond    = 3'b000;
        br_link    = 1'b0;
        br_pc      = 32'h0;
        br_target  = 32'h0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_eq_taken();
        test_forward();
        test_cond_table();
        test_wait();
        test_link();
        test_saturate();
        test_reset_mid_wait();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
